// File: rtl/split_mult_pipe_if.sv
// Handshake bundle for split_mult_pipe: operand input channel and product output channel.
interface split_mult_pipe_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           approx_en;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] P;

    modport master (
        output in_valid, A, B, approx_en, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, approx_en, out_ready,
        output in_ready, out_valid, P
    );
endinterface

// File: rtl/split_mult_pipe.sv
// Three-stage split-operand unsigned multiplier with valid/ready handshake and global stall.
// Build option MAC_EN adds acc_clr/acc_out: a running sum of every delivered product.
module split_mult_pipe #(
    parameter int W     = 8,
    parameter int L     = 1,
    parameter int ACC_G = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    split_mult_pipe_if.slave     bus
`ifdef MAC_EN
    ,
    input  logic                 acc_clr,
    output logic [2*W+ACC_G-1:0] acc_out
`endif
);
    localparam int HW  = W - L;
    localparam int HHW = 2 * HW;
    localparam int LLW = 2 * L;
    localparam int XW  = W + 1;
    localparam int PW  = 2 * W;

    if (W < 2 || L < 1 || L >= W || ACC_G < 0) begin : g_bad_param
        $error("split_mult_pipe: illegal W/L/ACC_G combination");
    end

    logic            adv;
    logic [3:1]      vld_pipe_q;
    logic [HW-1:0]   ah, bh;
    logic [L-1:0]    al, bl;
    logic [HHW-1:0]  phh_d, phh1_q, phh2_q;
    logic [W-1:0]    phl_d, plh_d, phl1_q, plh1_q;
    logic [LLW-1:0]  pll_d, pll1_q, pll2_q;
    logic [XW-1:0]   x_d, x2_q;
    logic [PW-1:0]   p_d, p_q;

    // Single stall signal: a full output stage that is not being drained freezes everything.
    assign adv = !vld_pipe_q[3] || bus.out_ready;

    assign {ah, al} = bus.A;
    assign {bh, bl} = bus.B;

    always_comb begin
        phh_d = HHW'(ah) * HHW'(bh);
        phl_d = W'(ah) * W'(bl);
        plh_d = W'(al) * W'(bh);
        pll_d = bus.approx_en ? '0 : LLW'(al) * LLW'(bl);
        x_d   = XW'(phl1_q) + XW'(plh1_q);
        p_d   = (PW'(phh2_q) << LLW) + (PW'(x2_q) << L) + PW'(pll2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            phh1_q     <= '0;
            phl1_q     <= '0;
            plh1_q     <= '0;
            pll1_q     <= '0;
            x2_q       <= '0;
            phh2_q     <= '0;
            pll2_q     <= '0;
            p_q        <= '0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[2:1], bus.in_valid};
            phh1_q     <= phh_d;
            phl1_q     <= phl_d;
            plh1_q     <= plh_d;
            pll1_q     <= pll_d;
            x2_q       <= x_d;
            phh2_q     <= phh1_q;
            pll2_q     <= pll1_q;
            p_q        <= p_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe_q[3];
    assign bus.P         = p_q;

`ifdef MAC_EN
    localparam int AW = PW + ACC_G;
    logic [AW-1:0] acc_d, acc_q;

    // Clear wins over a coincident output handshake; that product is dropped from the sum.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr)
            acc_d = '0;
        else if (vld_pipe_q[3] && bus.out_ready)
            acc_d = acc_q + AW'(p_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc_out = acc_q;
`endif
endmodule

// File: tb/tb_split_mult_pipe.sv
// Bench for split_mult_pipe: queue-based product model plus directed literal checks (W=8/L=1 and W=12/L=5).
module tb_split_mult_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    split_mult_pipe_if #(.W(8))  b8 ();
    split_mult_pipe_if #(.W(12)) b12 ();

`ifdef MAC_EN
    logic        acc_clr = 1'b0;
    logic        acc_clr12 = 1'b0;
    logic [23:0] acc_out;
    logic [31:0] acc_out12;
`endif

    split_mult_pipe #(.W(8), .L(1)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(b8)
`ifdef MAC_EN
        , .acc_clr(acc_clr), .acc_out(acc_out)
`endif
    );

    split_mult_pipe #(.W(12), .L(5)) u12 (
        .clk(clk), .rst_n(rst_n), .bus(b12)
`ifdef MAC_EN
        , .acc_clr(acc_clr12), .acc_out(acc_out12)
`endif
    );

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     n12out = 0;
    longint q8[$], q12[$], got8[$];
    int     gotc8[$], accc8[$];
    logic   held8 = 1'b0, held12 = 1'b0;
    longint hp8 = 0, hp12 = 0;

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Product as the spec defines it: exact A*B, minus the low x low term when approximating.
    function automatic longint model(int l, longint a, longint b, bit ax);
        longint m = (longint'(1) << l) - 1;
        return ax ? a * b - (a & m) * (b & m) : a * b;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q8.delete(); q12.delete();
            held8 = 1'b0; held12 = 1'b0;
        end else begin
            if (b8.out_valid && held8) chk("p8_stable", b8.P, hp8);
            held8 = b8.out_valid && !b8.out_ready; hp8 = b8.P;
            if (b8.out_valid && b8.out_ready) begin
                chk("out8_expected", q8.size() > 0, 1);
                if (q8.size() > 0) chk("p8", b8.P, q8.pop_front());
                got8.push_back(b8.P); gotc8.push_back(cyc);
            end
            if (b8.in_valid && b8.in_ready) begin
                q8.push_back(model(1, b8.A, b8.B, b8.approx_en));
                accc8.push_back(cyc);
            end

            if (b12.out_valid && held12) chk("p12_stable", b12.P, hp12);
            held12 = b12.out_valid && !b12.out_ready; hp12 = b12.P;
            if (b12.out_valid && b12.out_ready) begin
                chk("out12_expected", q12.size() > 0, 1);
                if (q12.size() > 0) chk("p12", b12.P, q12.pop_front());
                n12out++;
            end
            if (b12.in_valid && b12.in_ready)
                q12.push_back(model(5, b12.A, b12.B, b12.approx_en));
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send8(int a, int b, bit ax);
        logic ok = 1'b0;
        b8.in_valid = 1'b1; b8.A = 8'(a); b8.B = 8'(b); b8.approx_en = ax;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk); ok = b8.in_ready;
            @(posedge clk); #1;
        end
        b8.in_valid = 1'b0;
        chk("send8_accepted", ok, 1);
    endtask

    task automatic wait_got(string name, int n);
        for (int t = 0; t < 100 && got8.size() < n; t++) @(negedge clk);
        step(1);
        chk(name, got8.size(), n);
    endtask

    task automatic chk_got(string name, int i, longint exp);
        if (got8.size() > i) chk(name, got8[i], exp);
        else                 chk(name, -1, exp);
    endtask

    task automatic clear_logs();
        got8.delete(); gotc8.delete(); accc8.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n, idx, sent, guard;
        logic acc;
        int exp3[5] = '{2, 6, 12, 20, 30};

        b8.in_valid = 0; b8.A = 0; b8.B = 0; b8.approx_en = 0; b8.out_ready = 1;
        b12.in_valid = 0; b12.A = 0; b12.B = 0; b12.approx_en = 0; b12.out_ready = 1;

        chk("pin_model_exact", model(1, 255, 255, 0), 65025);
        chk("pin_model_approx", model(1, 3, 3, 1), 8);
        chk("pin_model_w12", model(5, 100, 37, 1), 3680);

        step(3);
        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_in_ready", b8.in_ready, 1);
        chk("rst_p", b8.P, 0);
        rst_n = 1'b1;
        step(2);

        // 1: latency and full-scale product
        clear_logs();
        send8(255, 255, 0);
        wait_got("t1_count", 1);
        if (gotc8.size() > 0 && accc8.size() > 0) chk("t1_latency", gotc8[0] - accc8[0], 3);
        else chk("t1_latency", -1, 3);
        chk_got("t1_p", 0, 65025);

        // 2: approx then exact, back to back
        clear_logs();
        b8.in_valid = 1; b8.A = 3; b8.B = 3; b8.approx_en = 1;
        step(1);
        b8.approx_en = 0;
        step(1);
        b8.in_valid = 0;
        wait_got("t2_count", 2);
        chk_got("t2_approx", 0, 8);
        chk_got("t2_exact", 1, 9);

        // 3: backpressure with 5 offered inputs
        clear_logs();
        b8.out_ready = 0; n = 0; idx = 0;
        b8.in_valid = 1; b8.A = 1; b8.B = 2; b8.approx_en = 0;
        repeat (6) begin
            @(negedge clk); acc = b8.in_ready;
            @(posedge clk); #1;
            if (acc) begin n++; idx++; b8.A = 8'(idx + 1); b8.B = 8'(idx + 2); end
        end
        chk("t3_accepts", n, 3);
        chk("t3_stall_ready", b8.in_ready, 0);
        b8.out_ready = 1;
        for (int i = n; i < 5; i++) send8(i + 1, i + 2, 0);
        wait_got("t3_count", 5);
        for (int i = 0; i < 5; i++) chk_got("t3_order", i, exp3[i]);

        // 4: reset with two transactions in flight
        clear_logs();
        b8.in_valid = 1; b8.A = 100; b8.B = 2;
        step(1);
        b8.A = 7; b8.B = 7;
        step(1);
        b8.in_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("t4_out_valid", b8.out_valid, 0);
        chk("t4_p_zero", b8.P, 0);
        chk("t4_in_ready", b8.in_ready, 1);
`ifdef MAC_EN
        chk("t4_acc_zero", acc_out, 0);
`endif
        step(3);
        rst_n = 1'b1;
        step(6);
        chk("t4_no_stale", got8.size(), 0);
        send8(10, 12, 0);
        wait_got("t4_count", 1);
        chk_got("t4_p", 0, 120);

        // 5: W=12 L=5 random operands with random sink readiness
        sent = 0; guard = 0;
        b12.in_valid = 1; b12.A = 12'($urandom); b12.B = 12'($urandom);
        while (sent < 1000 && guard < 20000) begin
            @(negedge clk); acc = b12.in_ready;
            @(posedge clk); #1; guard++;
            b12.out_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                sent++;
                if (sent < 1000) begin b12.A = 12'($urandom); b12.B = 12'($urandom); end
                else b12.in_valid = 0;
            end
        end
        b12.in_valid = 0;
        b12.out_ready = 1;
        step(8);
        chk("t5_sent", sent, 1000);
        chk("t5_delivered", n12out, 1000);

`ifdef MAC_EN
        // 6: accumulator
        acc_clr = 1; step(1); acc_clr = 0;
        chk("t6_cleared", acc_out, 0);
        send8(10, 10, 0);
        send8(20, 20, 0);
        step(6);
        chk("t6_sum", acc_out, 500);
        send8(30, 30, 0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (b8.out_valid) begin
                acc_clr = 1;
                @(posedge clk); #1;
                acc_clr = 0;
                break;
            end
        end
        step(3);
        chk("t6_clr_priority", acc_out, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
